// File: rtl/nn_mem_pkg.sv
// Shared types for the network memory server: channel ids, in-flight tag, widths.
package nn_mem_pkg;

   localparam int DW = 16;
   localparam int AW = 17;

   typedef enum logic [1:0] {
      CH_IN = 2'd0,
      CH_IH = 2'd1,
      CH_HO = 2'd2
   } ch_e;

   typedef struct packed {
      logic          valid;
      ch_e           ch;
      logic [AW-1:0] addr;
   } tag_t;

   function automatic ch_e next_ch(input ch_e c);
      return (c == CH_HO) ? CH_IN : ch_e'(c + 2'd1);
   endfunction

endpackage

// File: rtl/nn_rr_arb3.sv
// Three-request round-robin arbiter: one-hot grant starting at ptr, next pointer after the winner.
module nn_rr_arb3
   import nn_mem_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] ptr,
   output logic [2:0] gnt,
   output logic [1:0] ptr_nxt
);

   always_comb begin
      ch_e  c;
      logic found;
      gnt     = '0;
      ptr_nxt = ptr;
      c       = ch_e'(ptr);
      found   = 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
         if (!found && req[c]) begin
            gnt[c]  = 1'b1;
            ptr_nxt = next_ch(c);
            found   = 1'b1;
         end
         c = next_ch(c);
      end
   end

endmodule

// File: rtl/nn_mem_server.sv
// Serves addr_in/addr_ih/addr_ho from one shared memory, refetching a channel when its address changes.
// Optional NN_MEM_STATS_EN adds saturating stat_fetch / stat_stale counters.
module nn_mem_server
   import nn_mem_pkg::*;
#(
   parameter int             MAW     = 20,
   parameter logic [MAW-1:0] BASE_IN = 20'h00000,
   parameter logic [MAW-1:0] BASE_IH = 20'h20000,
   parameter logic [MAW-1:0] BASE_HO = 20'h40000,
   parameter int             MEM_LAT = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [16:0]    addr_in,
   input  logic [16:0]    addr_ih,
   input  logic [16:0]    addr_ho,
   output logic [15:0]    in,
   output logic [15:0]    wih,
   output logic [15:0]    who,
   output logic           vld_in,
   output logic           vld_ih,
   output logic           vld_ho,
   output logic           mem_rd_en,
   output logic [MAW-1:0] mem_addr,
   input  logic [15:0]    mem_rdata
`ifdef NN_MEM_STATS_EN
   ,
   output logic [31:0]    stat_fetch,
   output logic [31:0]    stat_stale
`endif
);

   logic [AW-1:0] cur_addr    [3];
   logic [AW-1:0] issued_addr [3];
   logic [AW-1:0] data_addr   [3];
   logic [DW-1:0] data_q      [3];
   logic [2:0]    issued;
   logic [2:0]    data_ok;
   logic [2:0]    req;
   logic [2:0]    gnt;
   logic          gnt_any;
   ch_e           gnt_ch;
   ch_e           ptr;
   logic [1:0]    ptr_nxt;
   tag_t          pipe [MEM_LAT];
   tag_t          ret;
   logic          ret_hit;

   function automatic logic [MAW-1:0] base_of(input ch_e c);
      case (c)
         CH_IH:   return BASE_IH;
         CH_HO:   return BASE_HO;
         default: return BASE_IN;
      endcase
   endfunction

   assign cur_addr[0] = addr_in;
   assign cur_addr[1] = addr_ih;
   assign cur_addr[2] = addr_ho;

   always_comb begin
      req = '0;
      for (int unsigned i = 0; i < 3; i++)
         req[i] = !issued[i] || (cur_addr[i] != issued_addr[i]);
   end

   nn_rr_arb3 u_arb (
      .req     (req),
      .ptr     (ptr),
      .gnt     (gnt),
      .ptr_nxt (ptr_nxt)
   );

   assign gnt_any = |gnt;
   assign gnt_ch  = gnt[1] ? CH_IH : (gnt[2] ? CH_HO : CH_IN);

   // A return is only useful if the channel still points at the address it was fetched for.
   assign ret     = pipe[MEM_LAT-1];
   assign ret_hit = ret.valid && (ret.addr == cur_addr[ret.ch]);

   always_ff @(posedge clk) begin
      if (rst) begin
         issued    <= '0;
         data_ok   <= '0;
         mem_rd_en <= 1'b0;
         mem_addr  <= '0;
         ptr       <= CH_IN;
         for (int unsigned i = 0; i < 3; i++) begin
            issued_addr[i] <= '0;
            data_addr[i]   <= '0;
            data_q[i]      <= '0;
         end
         for (int unsigned i = 0; i < MEM_LAT; i++)
            pipe[i] <= '0;
      end else begin
         mem_rd_en <= gnt_any;
         pipe[0]   <= '{valid: gnt_any, ch: gnt_ch, addr: cur_addr[gnt_ch]};
         for (int unsigned i = 1; i < MEM_LAT; i++)
            pipe[i] <= pipe[i-1];
         if (gnt_any) begin
            mem_addr            <= base_of(gnt_ch) + MAW'(cur_addr[gnt_ch]);
            issued[gnt_ch]      <= 1'b1;
            issued_addr[gnt_ch] <= cur_addr[gnt_ch];
            ptr                 <= ch_e'(ptr_nxt);
         end
         if (ret_hit) begin
            data_q[ret.ch]    <= mem_rdata;
            data_addr[ret.ch] <= ret.addr;
            data_ok[ret.ch]   <= 1'b1;
         end
      end
   end

   assign in     = data_q[0];
   assign wih    = data_q[1];
   assign who    = data_q[2];
   assign vld_in = data_ok[0] && (data_addr[0] == addr_in);
   assign vld_ih = data_ok[1] && (data_addr[1] == addr_ih);
   assign vld_ho = data_ok[2] && (data_addr[2] == addr_ho);

`ifdef NN_MEM_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_fetch <= '0;
         stat_stale <= '0;
      end else begin
         if (gnt_any && (stat_fetch != '1))
            stat_fetch <= stat_fetch + 32'd1;
         if (ret.valid && !ret_hit && (stat_stale != '1))
            stat_stale <= stat_stale + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_nn_mem_server.sv
// Directed bench: u1 runs MEM_LAT=1, u2 runs MEM_LAT=2 with BASE_HO=20'hF0000 to exercise address wrap.
module tb_nn_mem_server;

   logic        clk = 1'b0;
   logic        rst;
   logic [16:0] addr_in, addr_ih, addr_ho;

   logic [15:0] in1, wih1, who1, mrd1;
   logic        vin1, vih1, vho1, rd1;
   logic [19:0] ma1;
   logic [15:0] in2, wih2, who2, mrd2;
   logic        vin2, vih2, vho2, rd2;
   logic [19:0] ma2;
`ifdef NN_MEM_STATS_EN
   logic [31:0] sf1, ss1, sf2, ss2;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Memory models: data = addr[15:0]^A5A5, captured by the DUT MEM_LAT edges after the grant edge
   assign mrd1 = ma1[15:0] ^ 16'hA5A5;
   always @(posedge clk) mrd2 <= ma2[15:0] ^ 16'hA5A5;

   nn_mem_server #(.MEM_LAT(1)) u1 (
      .clk(clk), .rst(rst), .addr_in(addr_in), .addr_ih(addr_ih), .addr_ho(addr_ho),
      .in(in1), .wih(wih1), .who(who1), .vld_in(vin1), .vld_ih(vih1), .vld_ho(vho1),
      .mem_rd_en(rd1), .mem_addr(ma1), .mem_rdata(mrd1)
`ifdef NN_MEM_STATS_EN
      , .stat_fetch(sf1), .stat_stale(ss1)
`endif
   );

   nn_mem_server #(.MEM_LAT(2), .BASE_HO(20'hF0000)) u2 (
      .clk(clk), .rst(rst), .addr_in(addr_in), .addr_ih(addr_ih), .addr_ho(addr_ho),
      .in(in2), .wih(wih2), .who(who2), .vld_in(vin2), .vld_ih(vih2), .vld_ho(vho2),
      .mem_rd_en(rd2), .mem_addr(ma2), .mem_rdata(mrd2)
`ifdef NN_MEM_STATS_EN
      , .stat_fetch(sf2), .stat_stale(ss2)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; addr_in = '0; addr_ih = '0; addr_ho = '0;
      tick(2);
      chk("rst_in", in1, 0);
      chk("rst_wih", wih1, 0);
      chk("rst_who", who1, 0);
      chk("rst_rd_en", rd1, 0);
      chk("rst_addr", ma1, 0);
      chk("rst_vld", {vin1, vih1, vho1}, 0);

      // Startup fetch of all three channels
      rst = 1'b0;
      tick(); chk("boot_rd_en", rd1, 1); chk("boot_a0", ma1, 32'h00000);
      tick(); chk("boot_a1", ma1, 32'h20000); chk("boot_in", in1, 16'hA5A5);
      tick(); chk("boot_a2", ma1, 32'h40000); chk("boot_a2_u2", ma2, 32'hF0000);
      tick();
      chk("boot_idle", rd1, 0);
      chk("boot_data", {in1, wih1, who1}, {16'hA5A5, 16'hA5A5, 16'hA5A5});
      chk("boot_vld", {vin1, vih1, vho1}, 3'b111);
      tick(2);
      chk("boot_vld_u2", {vin2, vih2, vho2}, 3'b111);

      // Single-channel change
      addr_in = 17'd5;
      #1 chk("chg_vld_drop", vin1, 0);
      tick(); chk("chg_rd_en", rd1, 1); chk("chg_addr", ma1, 32'h00005); chk("chg_vld_lo", vin1, 0);
      tick(); chk("chg_in", in1, 16'hA5A0); chk("chg_vld_hi", vin1, 1); chk("chg_no_more", rd1, 0);
      tick(); chk("chg_idle", rd1, 0); chk("chg_others_vld", {vih1, vho1}, 2'b11);

      // Stale return on MEM_LAT=2
      addr_ih = 17'd3;
      tick(); chk("stale_a3", ma2, 32'h20003);
      addr_ih = 17'd4;
      tick();
      chk("stale_a4", ma2, 32'h20004); chk("stale_rd_en", rd2, 1);
      chk("stale_hold0", wih2, 16'hA5A5); chk("stale_vld0", vih2, 0);
      tick();
      chk("stale_hold1", wih2, 16'hA5A5); chk("stale_vld1", vih2, 0);
`ifdef NN_MEM_STATS_EN
      chk("stale_stat", ss2, 1);
`endif
      tick(); chk("stale_new", wih2, 16'hA5A1); chk("stale_vld2", vih2, 1);

      // Move pointer to IH via an IN grant, then change all three
      addr_in = 17'd7;
      tick(3);
      addr_in = 17'h10; addr_ih = 17'h11; addr_ho = 17'h12;
      tick(); chk("rr_ih", ma1, 32'h20011); chk("rr_rd0", rd1, 1);
      tick(); chk("rr_ho", ma1, 32'h40012); chk("rr_rd1", rd1, 1);
      tick(); chk("rr_in", ma1, 32'h00010); chk("rr_rd2", rd1, 1);
      tick();
      chk("rr_idle", rd1, 0);
      chk("rr_data", {in1, wih1, who1}, {16'hA5B5, 16'hA5B4, 16'hA5B7});
      chk("rr_vld", {vin1, vih1, vho1}, 3'b111);
      addr_in = 17'h20; addr_ih = 17'h21; addr_ho = 17'h1FFFF;
      tick(); chk("rr_ptr_ih", ma1, 32'h20021);
      tick(); chk("wrap_u1", ma1, 32'h5FFFF); chk("wrap_u2", ma2, 32'h0FFFF);
      tick(3);
      chk("wrap_who_u2", who2, 16'h5A5A); chk("wrap_vld_u2", vho2, 1);

      // Reset with two reads in flight on MEM_LAT=2
      addr_in = 17'h30; addr_ih = 17'h31;
      tick(2);
      rst = 1'b1;
      tick();
      chk("mid_rst_data", {in2, wih2, who2}, 0);
      chk("mid_rst_vld", {vin2, vih2, vho2}, 0);
      chk("mid_rst_rd", rd2, 0);
      chk("mid_rst_addr", ma2, 0);
      rst = 1'b0;
      tick();
      chk("post_rst_in", in2, 0); chk("post_rst_vld", vin2, 0);
      chk("post_rst_a0", ma2, 32'h00030); chk("post_rst_rd", rd2, 1);
      tick(); chk("post_rst_a1", ma2, 32'h20031);
      tick(); chk("post_rst_a2", ma2, 32'h0FFFF); chk("post_rst_in_d", in2, 16'hA595);
      tick(2);
      chk("post_rst_data", {wih2, who2}, {16'hA594, 16'h5A5A});
      chk("post_rst_vld_all", {vin2, vih2, vho2}, 3'b111);

      // Ten simultaneous changes, each held long enough to avoid stale returns
      for (int k = 1; k <= 10; k++) begin
         addr_in = 17'(32'h100 + k); addr_ih = 17'(32'h200 + k); addr_ho = 17'(32'h300 + k);
         tick(5);
      end
      chk("loop_u1", {in1, wih1, who1}, {16'hA4AF, 16'hA7AF, 16'hA6AF});
      chk("loop_u2", {in2, wih2, who2}, {16'hA4AF, 16'hA7AF, 16'hA6AF});
`ifdef NN_MEM_STATS_EN
      chk("stat_fetch_u1", sf1, 33); chk("stat_stale_u1", ss1, 0);
      chk("stat_fetch_u2", sf2, 33); chk("stat_stale_u2", ss2, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
